// File: rtl/rf_writeback_queue_if.sv
// rf_writeback_queue_if: producer, register-file and decode-probe signals of the writeback queue.
// Bypass data lines exist only when WB_BYPASS_EN is defined.
interface rf_writeback_queue_if #(parameter int DW = 32, parameter int AW = 5);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rd;
    logic [DW-1:0] in_data;
    logic          rf_busy;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] q_rs1;
    logic [AW-1:0] q_rs2;
    logic          hz_rs1;
    logic          hz_rs2;
`ifdef WB_BYPASS_EN
    logic [DW-1:0] byp_data1;
    logic [DW-1:0] byp_data2;
`endif
    modport master (
        output in_valid, in_rd, in_data, rf_busy, q_rs1, q_rs2,
        input  in_ready, rf_we, rf_waddr, rf_wdata, hz_rs1, hz_rs2
`ifdef WB_BYPASS_EN
        , input byp_data1, byp_data2
`endif
    );
    modport slave (
        input  in_valid, in_rd, in_data, rf_busy, q_rs1, q_rs2,
        output in_ready, rf_we, rf_waddr, rf_wdata, hz_rs1, hz_rs2
`ifdef WB_BYPASS_EN
        , output byp_data1, byp_data2
`endif
    );
endinterface

// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue: in-order result FIFO draining one write per cycle into the register file.
// Define WB_BYPASS_EN to forward the youngest pending value for each decode source register.
module rf_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    rf_writeback_queue_if.slave    wb,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
    typedef enum logic [1:0] {EMPTY, ACTIVE, FULL} occ_e;
    occ_e          state, state_nxt;
    logic [AW-1:0] rd_q   [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0] rptr, wptr, idx;
    logic [PW:0]   count_nxt;
    logic          push, enq, pop;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          hz1, hz2;
    assign wb.in_ready = state != FULL;
    assign push        = wb.in_valid && wb.in_ready;
    // x0 results complete the handshake but never occupy an entry
    assign enq         = push && wb.in_rd != '0;
    assign pop         = state != EMPTY && !wb.rf_busy;
    assign wb.rf_we    = rf_we;
    assign wb.rf_waddr = rf_waddr;
    assign wb.rf_wdata = rf_wdata;
    assign wb.hz_rs1   = hz1;
    assign wb.hz_rs2   = hz2;
    always_comb begin
        count_nxt = enq && !pop ? count + (PW+1)'(1) : pop && !enq ? count - (PW+1)'(1) : count;
        state_nxt = count_nxt == '0 ? EMPTY : count_nxt == FULL_CNT ? FULL : ACTIVE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            count    <= '0;
            rptr     <= '0;
            wptr     <= '0;
            vld      <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            rf_we <= pop;
            if (enq) begin
                vld[wptr] <= 1'b1;
                wptr      <= wptr + PW'(1);
            end
            if (pop) begin
                rf_waddr  <= rd_q[rptr];
                rf_wdata  <= data_q[rptr];
                vld[rptr] <= 1'b0;
                rptr      <= rptr + PW'(1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (enq) begin
            rd_q[wptr]   <= wb.in_rd;
            data_q[wptr] <= wb.in_data;
        end
    end
`ifdef WB_BYPASS_EN
    logic [DW-1:0] byp1, byp2;
    assign wb.byp_data1 = hz1 ? byp1 : '0;
    assign wb.byp_data2 = hz2 ? byp2 : '0;
`endif
    // scan oldest to youngest so the last hit is the newest value; output stage is oldest of all
    always_comb begin
        idx = rptr;
        hz1 = rf_we && rf_waddr == wb.q_rs1;
        hz2 = rf_we && rf_waddr == wb.q_rs2;
`ifdef WB_BYPASS_EN
        byp1 = rf_wdata;
        byp2 = rf_wdata;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = rptr + PW'(k);
            if (vld[idx] && rd_q[idx] == wb.q_rs1) begin
                hz1 = 1'b1;
`ifdef WB_BYPASS_EN
                byp1 = data_q[idx];
`endif
            end
            if (vld[idx] && rd_q[idx] == wb.q_rs2) begin
                hz2 = 1'b1;
`ifdef WB_BYPASS_EN
                byp2 = data_q[idx];
`endif
            end
        end
        hz1 = hz1 && wb.q_rs1 != '0;
        hz2 = hz2 && wb.q_rs2 != '0;
    end
endmodule

// File: tb/tb_rf_writeback_queue.sv
// tb_rf_writeback_queue: directed vectors with hand-computed expectations for rf_writeback_queue.
// Bypass checks compile in only when WB_BYPASS_EN is defined.
module tb_rf_writeback_queue;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] count;
    int         passed = 0;
    int         total = 0;
    rf_writeback_queue_if #(.DW(32), .AW(5)) wb ();
    rf_writeback_queue #(.DEPTH(4), .DW(32), .AW(5)) dut (.clk(clk), .rst(rst), .wb(wb), .count(count));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [4:0] rd, input logic [31:0] d);
        wb.in_valid = 1'b1;
        wb.in_rd    = rd;
        wb.in_data  = d;
        tick();
        wb.in_valid = 1'b0;
    endtask
    task automatic expect_wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d, input int c);
        check({tag, "_we"}, 64'(wb.rf_we), 64'(we));
        check({tag, "_addr"}, 64'(wb.rf_waddr), 64'(a));
        check({tag, "_data"}, 64'(wb.rf_wdata), 64'(d));
        check({tag, "_count"}, 64'(count), 64'(c));
    endtask
    initial begin
        wb.in_valid = 1'b0;
        wb.in_rd    = '0;
        wb.in_data  = '0;
        wb.rf_busy  = 1'b0;
        wb.q_rs1    = '0;
        wb.q_rs2    = '0;
        #1;
        expect_wr("rst", 1'b0, 5'd0, 32'h0, 0);
        check("rst_ready", 64'(wb.in_ready), 64'd1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        // single push drains on the next edge
        wb.q_rs1 = 5'd5;
        push(5'd5, 32'hDEADBEEF);
        expect_wr("t2_queued", 1'b0, 5'd0, 32'h0, 1);
        check("t2_hz_queued", 64'(wb.hz_rs1), 64'd1);
        tick();
        expect_wr("t2_pop", 1'b1, 5'd5, 32'hDEADBEEF, 0);
        check("t2_hz_outstage", 64'(wb.hz_rs1), 64'd1);
        tick();
        expect_wr("t2_idle", 1'b0, 5'd5, 32'hDEADBEEF, 0);
        check("t2_hz_clear", 64'(wb.hz_rs1), 64'd0);
        // fill while busy, then drain with a simultaneous push that wraps the pointers
        wb.rf_busy = 1'b1;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 'h11));
        check("t3_full_count", 64'(count), 64'd4);
        check("t3_full_ready", 64'(wb.in_ready), 64'd0);
        wb.in_valid = 1'b1;
        wb.in_rd    = 5'd6;
        wb.in_data  = 32'h66;
        wb.rf_busy  = 1'b0;
        #1;
        check("t3_full_pop_ready", 64'(wb.in_ready), 64'd0);
        tick();
        expect_wr("t3_pop1", 1'b1, 5'd1, 32'h11, 3);
        check("t3_ready_after_pop", 64'(wb.in_ready), 64'd1);
        tick();
        wb.in_valid = 1'b0;
        expect_wr("t3_pop2_push", 1'b1, 5'd2, 32'h22, 3);
        tick();
        expect_wr("t3_pop3", 1'b1, 5'd3, 32'h33, 2);
        tick();
        expect_wr("t3_pop4", 1'b1, 5'd4, 32'h44, 1);
        tick();
        expect_wr("t3_pop6", 1'b1, 5'd6, 32'h66, 0);
        tick();
        expect_wr("t3_idle", 1'b0, 5'd6, 32'h66, 0);
        // x0 result is accepted but dropped
        wb.q_rs1 = 5'd0;
        check("t4_ready", 64'(wb.in_ready), 64'd1);
        push(5'd0, 32'hFFFFFFFF);
        expect_wr("t4_after_push", 1'b0, 5'd6, 32'h66, 0);
        check("t4_hz_x0", 64'(wb.hz_rs1), 64'd0);
        tick();
        expect_wr("t4_no_write", 1'b0, 5'd6, 32'h66, 0);
        // same rd twice: hazard and youngest-value forwarding
        wb.rf_busy = 1'b1;
        push(5'd7, 32'hA);
        push(5'd7, 32'hB);
        wb.q_rs1 = 5'd7;
        wb.q_rs2 = 5'd3;
        #1;
        check("t5_hz1", 64'(wb.hz_rs1), 64'd1);
        check("t5_hz2_miss", 64'(wb.hz_rs2), 64'd0);
`ifdef WB_BYPASS_EN
        check("t5_byp1_youngest", 64'(wb.byp_data1), 64'hB);
        check("t5_byp2_zero", 64'(wb.byp_data2), 64'h0);
`endif
        wb.q_rs1 = 5'd0;
        wb.q_rs2 = 5'd7;
        #1;
        check("t5_hz1_x0", 64'(wb.hz_rs1), 64'd0);
        check("t5_hz2_hit", 64'(wb.hz_rs2), 64'd1);
        wb.q_rs1   = 5'd7;
        wb.rf_busy = 1'b0;
        tick();
        expect_wr("t5_popA", 1'b1, 5'd7, 32'hA, 1);
        check("t5_hz_mixed", 64'(wb.hz_rs1), 64'd1);
`ifdef WB_BYPASS_EN
        check("t5_byp_queue_over_out", 64'(wb.byp_data1), 64'hB);
`endif
        tick();
        expect_wr("t5_popB", 1'b1, 5'd7, 32'hB, 0);
`ifdef WB_BYPASS_EN
        check("t5_byp_outstage", 64'(wb.byp_data1), 64'hB);
`endif
        tick();
        check("t5_hz_done", 64'(wb.hz_rs1), 64'd0);
        // reset while the output stage is writing
        push(5'd9, 32'h99);
        push(5'd10, 32'hAA);
        expect_wr("t1_pre_rst", 1'b1, 5'd9, 32'h99, 1);
        rst = 1'b1;
        #1;
        expect_wr("t1_rst", 1'b0, 5'd0, 32'h0, 0);
        check("t1_rst_ready", 64'(wb.in_ready), 64'd1);
        rst = 1'b0;
        tick();
        expect_wr("t1_no_write", 1'b0, 5'd0, 32'h0, 0);
        // reset discards entries held back by a busy port
        wb.rf_busy = 1'b1;
        push(5'd1, 32'h1);
        push(5'd2, 32'h2);
        push(5'd3, 32'h3);
        wb.q_rs1 = 5'd2;
        wb.q_rs2 = 5'd3;
        #1;
        check("t6_count_before", 64'(count), 64'd3);
        rst = 1'b1;
        #1;
        check("t6_count_rst", 64'(count), 64'd0);
        check("t6_hz1_rst", 64'(wb.hz_rs1), 64'd0);
        check("t6_hz2_rst", 64'(wb.hz_rs2), 64'd0);
        rst = 1'b0;
        wb.rf_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_no_write", 64'(wb.rf_we), 64'd0);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
